// File: rtl/playback_worker.sv
// Buffered AXI4-Stream playback engine: loads one packet into block RAM from the
// DMA side, then replays it on the DAC side for N passes or until stopped.
module playback_worker #(
   parameter int C_S_AXIS_TDATA_WIDTH = 32,
   parameter int C_M_AXIS_TDATA_WIDTH = 32,
   parameter int ADDR_WIDTH           = 10
) (
   input  logic                                S_AXIS_ACLK,
   input  logic                                S_AXIS_ARESET,
   output logic                                S_AXIS_TREADY,
   input  logic [C_S_AXIS_TDATA_WIDTH-1:0]     S_AXIS_TDATA,
   input  logic [(C_S_AXIS_TDATA_WIDTH/8)-1:0] S_AXIS_TSTRB,
   input  logic                                S_AXIS_TLAST,
   input  logic                                S_AXIS_TVALID,
   output logic                                M_AXIS_TVALID,
   output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
   output logic [(C_M_AXIS_TDATA_WIDTH/8)-1:0] M_AXIS_TSTRB,
   output logic                                M_AXIS_TLAST,
   input  logic                                M_AXIS_TREADY,
   input  logic [31:0]                         play_count,
   input  logic                                play_valid,
   output logic                                play_ready,
   input  logic                                stop,
   output logic [ADDR_WIDTH:0]                 loaded_len,
   output logic                                overflow,
   output logic                                busy
);

   localparam int DW    = C_M_AXIS_TDATA_WIDTH;
   localparam int LW    = ADDR_WIDTH + 1;
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_LEN = LW'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_PLAY
   } state_t;

   state_t                state;
   logic [ADDR_WIDTH:0]   wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [31:0]           pass_cnt;
   logic                  continuous;
   logic                  draining;

   logic [DW-1:0]         mem [DEPTH];
   logic [DW-1:0]         rd_q;
   logic                  rd_vld;
   logic                  rd_last;

   logic [DW-1:0]         head_data;
   logic                  head_last;
   logic [DW-1:0]         tail_data;
   logic                  tail_last;
   logic [1:0]            occ;

   logic                  s_fire;
   logic                  m_fire;
   logic                  play_fire;
   logic [1:0]            occ_after;
   logic                  rd_en;
   logic                  issue_last;
   logic                  wr_en;
   logic                  unused_tstrb;

   assign unused_tstrb  = ^S_AXIS_TSTRB;

   assign S_AXIS_TREADY = (state != S_PLAY);
   // A pending load beat always beats a play command in IDLE.
   assign play_ready    = (state == S_IDLE) && !S_AXIS_TVALID;
   assign busy          = (state != S_IDLE);

   assign s_fire    = S_AXIS_TVALID && S_AXIS_TREADY;
   assign m_fire    = M_AXIS_TVALID && M_AXIS_TREADY;
   assign play_fire = play_valid && play_ready;

   assign M_AXIS_TVALID = (occ != 2'd0);
   assign M_AXIS_TDATA  = head_data;
   assign M_AXIS_TLAST  = head_last;
   assign M_AXIS_TSTRB  = '1;

   // Occupancy after this edge, counting the beat landing from RAM and the one leaving;
   // issuing on that figure keeps a full-rate stream free of bubbles.
   assign occ_after  = occ + {1'b0, rd_vld} - {1'b0, m_fire};
   assign rd_en      = (state == S_PLAY) && !draining && !occ_after[1];
   assign issue_last = ({1'b0, rd_ptr} == (loaded_len - LW'(1)));

   // wr_ptr rests at 0 in IDLE and saturates at DEPTH, so its top bit marks discarded beats.
   assign wr_en = s_fire && !wr_ptr[ADDR_WIDTH];

   // NOTE: the sample RAM has no reset so it maps onto block RAM; only control state is reset.
   always_ff @(posedge S_AXIS_ACLK) begin
      if (wr_en) begin
         mem[wr_ptr[ADDR_WIDTH-1:0]] <= S_AXIS_TDATA;
      end
      if (rd_en) begin
         rd_q <= mem[rd_ptr];
      end
   end

   // NOTE: every sequential block uses non-blocking assignments so all registers see
   // pre-edge values of one another, independent of block ordering.
   always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
      if (S_AXIS_ARESET) begin
         state      <= S_IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         pass_cnt   <= '0;
         continuous <= 1'b0;
         draining   <= 1'b0;
         loaded_len <= '0;
         overflow   <= 1'b0;
      end else begin
         overflow <= 1'b0;
         case (state)
            S_IDLE: begin
               if (s_fire) begin
                  if (S_AXIS_TLAST) begin
                     loaded_len <= LW'(1);
                  end else begin
                     wr_ptr <= LW'(1);
                     state  <= S_LOAD;
                  end
               end else if (play_fire) begin
                  state      <= S_PLAY;
                  rd_ptr     <= '0;
                  pass_cnt   <= play_count;
                  continuous <= (play_count == 32'd0);
                  draining   <= (loaded_len == '0);
               end
            end

            S_LOAD: begin
               if (s_fire) begin
                  if (S_AXIS_TLAST) begin
                     loaded_len <= wr_ptr[ADDR_WIDTH] ? DEPTH_LEN : wr_ptr + LW'(1);
                     overflow   <= wr_ptr[ADDR_WIDTH];
                     wr_ptr     <= '0;
                     state      <= S_IDLE;
                  end else if (!wr_ptr[ADDR_WIDTH]) begin
                     wr_ptr <= wr_ptr + LW'(1);
                  end
               end
            end

            S_PLAY: begin
               if (rd_en) begin
                  if (issue_last) begin
                     rd_ptr <= '0;
                     if (!continuous) begin
                        pass_cnt <= pass_cnt - 32'd1;
                     end
                     if (stop || (!continuous && pass_cnt == 32'd1)) begin
                        draining <= 1'b1;
                     end
                  end else begin
                     rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
                  end
               end
               // Leave once nothing is in flight and the final beat is handed off this edge.
               if (draining && !rd_vld && occ_after == 2'd0) begin
                  state <= S_IDLE;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
      if (S_AXIS_ARESET) begin
         rd_vld  <= 1'b0;
         rd_last <= 1'b0;
      end else begin
         rd_vld <= rd_en;
         if (rd_en) begin
            rd_last <= issue_last;
         end
      end
   end

   // Two-entry output buffer; head drives the M side and only moves on pop or when empty.
   always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
      if (S_AXIS_ARESET) begin
         occ       <= 2'd0;
         head_data <= '0;
         head_last <= 1'b0;
         tail_data <= '0;
         tail_last <= 1'b0;
      end else begin
         occ <= occ_after;
         case ({rd_vld, m_fire})
            2'b10: begin
               if (occ == 2'd0) begin
                  head_data <= rd_q;
                  head_last <= rd_last;
               end else begin
                  tail_data <= rd_q;
                  tail_last <= rd_last;
               end
            end
            2'b01: begin
               head_data <= tail_data;
               head_last <= tail_last;
            end
            2'b11: begin
               if (occ == 2'd1) begin
                  head_data <= rd_q;
                  head_last <= rd_last;
               end else begin
                  head_data <= tail_data;
                  head_last <= tail_last;
                  tail_data <= rd_q;
                  tail_last <= rd_last;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_playback_worker.sv
// Self-checking bench for playback_worker: table-driven load/play scenarios, hand-written
// corner sequences and randomized runs checked against a queue-based stream model.
`timescale 1ns/1ps
module tb_playback_worker;

   localparam int AW    = 10;
   localparam int DW    = 32;
   localparam int DEPTH = 1 << AW;

   logic            clk = 1'b0;
   logic            rst;
   logic            s_tready;
   logic [DW-1:0]   s_tdata;
   logic [DW/8-1:0] s_tstrb;
   logic            s_tlast;
   logic            s_tvalid;
   logic            m_tvalid;
   logic [DW-1:0]   m_tdata;
   logic [DW/8-1:0] m_tstrb;
   logic            m_tlast;
   logic            m_tready;
   logic [31:0]     play_count;
   logic            play_valid;
   logic            play_ready;
   logic            stop;
   logic [AW:0]     loaded_len;
   logic            overflow;
   logic            busy;

   always #5 clk = ~clk;

   playback_worker #(
      .C_S_AXIS_TDATA_WIDTH(DW),
      .C_M_AXIS_TDATA_WIDTH(DW),
      .ADDR_WIDTH(AW)
   ) dut (
      .S_AXIS_ACLK(clk),
      .S_AXIS_ARESET(rst),
      .S_AXIS_TREADY(s_tready),
      .S_AXIS_TDATA(s_tdata),
      .S_AXIS_TSTRB(s_tstrb),
      .S_AXIS_TLAST(s_tlast),
      .S_AXIS_TVALID(s_tvalid),
      .M_AXIS_TVALID(m_tvalid),
      .M_AXIS_TDATA(m_tdata),
      .M_AXIS_TSTRB(m_tstrb),
      .M_AXIS_TLAST(m_tlast),
      .M_AXIS_TREADY(m_tready),
      .play_count(play_count),
      .play_valid(play_valid),
      .play_ready(play_ready),
      .stop(stop),
      .loaded_len(loaded_len),
      .overflow(overflow),
      .busy(busy)
   );

   typedef struct packed {
      logic          last;
      logic [DW-1:0] data;
   } beat_t;

   typedef struct {
      int n_load;
      int pcount;
      int pct;
      int exp_len;
      bit exp_ovf;
      int exp_beats;
   } vec_t;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [DW-1:0] model_buf [DEPTH];
   int          model_len = 0;
   beat_t       exp_q [$];
   bit          mon_en = 1'b0;
   int          beats = 0;
   bit          prev_stall = 1'b0;
   beat_t       prev_beat;
   int          ready_pct = 100;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Stream monitor: every handshake is matched against the model queue, stalls must hold.
   always @(negedge clk) begin
      if (!mon_en) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_hold", {m_tvalid, m_tlast, m_tdata}, {1'b1, prev_beat});
         end
         if (m_tvalid && m_tready) begin
            beats++;
            if (exp_q.size() == 0) begin
               check("extra_beat_valid", m_tvalid, 1'b0);
            end else begin
               check("beat", {m_tlast, m_tdata}, exp_q.pop_front());
            end
         end
         prev_stall = m_tvalid && !m_tready;
         prev_beat  = {m_tlast, m_tdata};
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      m_tready = ($urandom_range(0, 99) < ready_pct);
   endtask

   task automatic load(input int n, input int exp_len, input bit exp_ovf);
      int prev_len;
      prev_len = model_len;
      for (int i = 0; i < n; i++) begin
         s_tdata  = $urandom;
         s_tlast  = (i == n - 1);
         s_tvalid = 1'b1;
         if (i == 0) check("load_s_tready", s_tready, 1'b1);
         if (i == n / 2 && n > 2) check("len_hold_during_load", loaded_len, prev_len);
         if (i < DEPTH) model_buf[i] = s_tdata;
         tick();
      end
      s_tvalid  = 1'b0;
      s_tlast   = 1'b0;
      model_len = (n > DEPTH) ? DEPTH : n;
      check("loaded_len", loaded_len, exp_len);
      check("overflow_pulse", overflow, exp_ovf);
      check("idle_after_load", busy, 1'b0);
      tick();
      check("overflow_clear", overflow, 1'b0);
   endtask

   // passes: how many whole passes the model expects; stop_at: cycle after accept to raise stop (-1 none).
   task automatic play(input int pc, input int passes, input int pct, input int stop_at);
      int exp_beats;
      int k;
      int limit;
      ready_pct = pct;
      m_tready  = ($urandom_range(0, 99) < ready_pct);
      exp_q.delete();
      beats = 0;
      for (int p = 0; p < passes; p++) begin
         for (int i = 0; i < model_len; i++) begin
            exp_q.push_back({(i == model_len - 1), model_buf[i]});
         end
      end
      exp_beats = passes * model_len;
      limit     = exp_beats * 20 + 50;
      mon_en    = 1'b1;
      play_count = pc;
      play_valid = 1'b1;
      for (int w = 0; w < 20 && !play_ready; w++) tick();
      check("play_ready", play_ready, 1'b1);
      tick();
      play_valid = 1'b0;
      check("busy_on_accept", busy, 1'b1);
      k = 0;
      while (busy && k < limit) begin
         if (k == stop_at) stop = 1'b1;
         if (k == 1 && model_len > 0) check("tvalid_low_n1", m_tvalid, 1'b0);
         if (k == 2 && model_len > 0) check("tvalid_high_n2", m_tvalid, 1'b1);
         if (model_len == 0) check("empty_no_tvalid", m_tvalid, 1'b0);
         tick();
         k++;
      end
      stop = 1'b0;
      check("play_done", busy, 1'b0);
      if (pct == 100) check("play_cycles", k, (model_len == 0) ? 1 : exp_beats + 2);
      check("beat_count", beats, exp_beats);
      check("model_drained", exp_q.size(), 0);
      check("tvalid_after", m_tvalid, 1'b0);
      mon_en = 1'b0;
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs [7];
      int   n;
      int   pc;
      int   stop_at;

      vecs[0] = '{4,         2, 100, 4,     1'b0, 8};
      vecs[1] = '{DEPTH + 3, 1, 100, DEPTH, 1'b1, DEPTH};
      vecs[2] = '{5,         2, 50,  5,     1'b0, 10};
      vecs[3] = '{1,         3, 100, 1,     1'b0, 3};
      vecs[4] = '{DEPTH,     1, 60,  DEPTH, 1'b0, DEPTH};
      vecs[5] = '{7,         3, 30,  7,     1'b0, 21};
      vecs[6] = '{2,         1, 50,  2,     1'b0, 2};

      rst        = 1'b1;
      s_tdata    = '0;
      s_tstrb    = '0;
      s_tlast    = 1'b0;
      s_tvalid   = 1'b0;
      m_tready   = 1'b1;
      play_count = '0;
      play_valid = 1'b0;
      stop       = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_tvalid", m_tvalid, 1'b0);
      check("rst_tlast", m_tlast, 1'b0);
      check("rst_overflow", overflow, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_s_tready", s_tready, 1'b1);
      check("rst_play_ready", play_ready, 1'b1);
      check("rst_loaded_len", loaded_len, 0);
      check("tstrb_ones", m_tstrb, 4'hF);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // Empty buffer: command taken, no beats, back to IDLE after one cycle.
      play(1, 0, 100, -1);

      foreach (vecs[v]) begin
         load(vecs[v].n_load, vecs[v].exp_len, vecs[v].exp_ovf);
         play(vecs[v].pcount, vecs[v].pcount, vecs[v].pct, -1);
         check("vec_beats", beats, vecs[v].exp_beats);
      end

      // Continuous mode, stop raised while the read side is inside pass 5 (TLAST of pass p
      // is read at cycle p*len-1 after accept, so stop at cycle 13 ends after pass 5).
      load(3, 3, 1'b0);
      play(0, 5, 100, 13);
      check("stop_beats", beats, 15);

      // Load beat and play command together in IDLE: the load wins.
      s_tdata    = $urandom;
      s_tlast    = 1'b0;
      s_tvalid   = 1'b1;
      play_count = 32'd1;
      play_valid = 1'b1;
      #1;
      check("simul_play_ready", play_ready, 1'b0);
      check("simul_s_tready", s_tready, 1'b1);
      model_buf[0] = s_tdata;
      tick();
      play_valid = 1'b0;
      check("simul_busy_load", busy, 1'b1);
      for (int i = 1; i < 3; i++) begin
         s_tdata = $urandom;
         s_tlast = (i == 2);
         model_buf[i] = s_tdata;
         tick();
      end
      s_tvalid  = 1'b0;
      s_tlast   = 1'b0;
      model_len = 3;
      check("simul_loaded_len", loaded_len, 3);
      check("simul_no_play", m_tvalid, 1'b0);
      tick();
      check("simul_idle", busy, 1'b0);
      play(1, 1, 100, -1);

      // Randomized runs against the model.
      for (int r = 0; r < 8; r++) begin
         n = ($urandom_range(0, 5) == 0) ? DEPTH + $urandom_range(1, 4) : $urandom_range(1, 40);
         load(n, (n > DEPTH) ? DEPTH : n, n > DEPTH);
         if ($urandom_range(0, 3) == 0) begin
            stop_at = $urandom_range(0, 3 * model_len + 5);
            play(0, (stop_at + model_len) / model_len, 100, stop_at);
         end else begin
            pc = $urandom_range(1, 3);
            play(pc, pc, $urandom_range(25, 100), -1);
         end
      end

      // Reset in the middle of pass 1.
      load(5, 5, 1'b0);
      ready_pct  = 100;
      m_tready   = 1'b1;
      play_count = 32'd2;
      play_valid = 1'b1;
      tick();
      play_valid = 1'b0;
      repeat (3) tick();
      check("pre_reset_tvalid", m_tvalid, 1'b1);
      rst = 1'b1;
      #1;
      check("mid_rst_tvalid", m_tvalid, 1'b0);
      check("mid_rst_tlast", m_tlast, 1'b0);
      check("mid_rst_loaded_len", loaded_len, 0);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_s_tready", s_tready, 1'b1);
      check("mid_rst_play_ready", play_ready, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      model_len = 0;
      tick();
      play(1, 0, 100, -1);
      load(3, 3, 1'b0);
      play(2, 2, 100, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/playback_worker.md
Name: playback_worker

Overview:
- Transmit-side counterpart of the capture-path stream gate.
- Loads one AXI4-Stream packet from the DMA (S side) into an internal block-RAM buffer.
- On command, replays that buffer on the M side toward the DAC path, a programmed number of passes or continuously until stopped.
- Sits between the MM2S DMA and the DAC sample stream in the capture system.

Parameters:
- C_S_AXIS_TDATA_WIDTH, 32, input sample width; must equal C_M_AXIS_TDATA_WIDTH.
- C_M_AXIS_TDATA_WIDTH, 32, output sample width.
- ADDR_WIDTH, 10, buffer address width; DEPTH = 2**ADDR_WIDTH samples.

Ports:
- S_AXIS_ACLK  in  1  single clock for all logic.
- S_AXIS_ARESET  in  1  asynchronous, active-high reset.
- S_AXIS_TREADY  out  1  load-side ready.
- S_AXIS_TDATA  in  C_S_AXIS_TDATA_WIDTH  load data.
- S_AXIS_TSTRB  in  C_S_AXIS_TDATA_WIDTH/8  ignored.
- S_AXIS_TLAST  in  1  end of load packet.
- S_AXIS_TVALID  in  1  load data valid.
- M_AXIS_TVALID  out  1  playback data valid.
- M_AXIS_TDATA  out  C_M_AXIS_TDATA_WIDTH  playback sample.
- M_AXIS_TSTRB  out  C_M_AXIS_TDATA_WIDTH/8  constant all ones.
- M_AXIS_TLAST  out  1  last sample of each pass.
- M_AXIS_TREADY  in  1  downstream ready.
- play_count  in  32  passes to play; 0 = continuous.
- play_valid  in  1  play command valid.
- play_ready  out  1  command accepted when play_valid && play_ready.
- stop  in  1  level; end playback at the next pass boundary.
- loaded_len  out  ADDR_WIDTH+1  samples in the current buffer image.
- overflow  out  1  one-cycle pulse when a load packet exceeded DEPTH.
- busy  out  1  high in LOAD or PLAY.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, all pointers 0, pass counter 0, loaded_len=0.
  - Outputs low: M_AXIS_TVALID=0, M_AXIS_TLAST=0, overflow=0, busy=0.
  - S_AXIS_TREADY=1 and play_ready=1, reflecting IDLE.
  - Output pipeline flushed. Reset mid-PLAY drops in-flight beats; no TLAST is owed.
- States:
  - IDLE: S_AXIS_TREADY=1, play_ready=1.
    - S beat accepted -> writes address 0, wr_ptr=1, go to LOAD. If that beat has TLAST, finish the load immediately: loaded_len=1, stay IDLE.
    - Otherwise, play command accepted -> PLAY.
    - Simultaneous S beat and play command: the load wins; play_ready is combinationally 0 whenever S_AXIS_TVALID=1 in IDLE.
  - LOAD: S_AXIS_TREADY=1, play_ready=0.
    - Each beat writes buffer[wr_ptr] if wr_ptr<DEPTH, then increments wr_ptr (saturates at DEPTH).
    - Beats at or after wr_ptr=DEPTH are accepted and discarded.
    - On the TLAST beat: loaded_len = min(count, DEPTH); overflow pulses the next cycle if count>DEPTH; go to IDLE.
    - loaded_len keeps its old value until TLAST.
  - PLAY: S_AXIS_TREADY=0, play_ready=0, busy=1.
    - On entry: if loaded_len==0, return to IDLE next cycle with no output beats.
    - Otherwise rd_ptr=0; pass counter = play_count.
- Playback pipeline:
  - BRAM has 1-cycle read latency, feeding a 2-entry output buffer.
  - Read issued when occupancy + in-flight < 2.
  - Command accepted at edge N -> M_AXIS_TVALID=1 at edge N+2.
  - With M_AXIS_TREADY held 1: one beat per cycle, no bubbles, including across pass wrap.
  - TDATA/TLAST stable while TVALID && !TREADY.
- Pass rules:
  - Sample index loaded_len-1 carries TLAST=1.
  - After it, rd_ptr wraps to 0.
  - Pass counter decrements when the TLAST beat is issued to the read side (finite mode only).
  - Playback finishes when the counter reaches 0 (finite mode), or when stop is sampled high on the cycle the TLAST beat is issued (either mode).
  - After the final TLAST handshake completes, go to IDLE. No beats are read past the final TLAST.
  - stop asserted mid-pass always completes the current pass.
- loaded_len=1: every beat has TLAST=1.

Test Plan:
- Load 4-beat packet (0xA0..0xA3, TLAST on 4th); play_count=2, TREADY=1 -> 8 consecutive beats A0..A3,A0..A3 starting 2 cycles after accept; TLAST on beats 4 and 8; busy falls after beat 8.
- Load DEPTH+3 beats -> all accepted; loaded_len=DEPTH; overflow pulses once. Play 1 pass -> DEPTH beats of the first DEPTH samples.
- play_count=0 with 3-sample buffer, stop raised mid 5th pass -> 5th pass completes (15 beats total); last beat TLAST=1; then IDLE.
- Random TREADY backpressure (50%) on 2-pass, 5-sample play -> exact sequence preserved; no drops or duplicates; TDATA stable while stalled.
- Play with loaded_len=0 -> command accepted; TVALID never rises; returns to IDLE in 1 cycle. Simultaneous S_AXIS_TVALID and play_valid in IDLE -> load taken, play_ready=0.
- Assert S_AXIS_ARESET during pass 1 -> TVALID drops immediately; loaded_len=0; next load/play behaves as from power-up.
